// File: rtl/baudot_pkg.sv
// Shared definitions for the Baudot receive path and the downstream converter.
// Contents: receiver FSM state type, ITA2 shift codes, character width and a
// 3-input majority helper used by the line filter.
package baudot_pkg;

    localparam int unsigned BAUDOT_BITS = 5;

    localparam logic [BAUDOT_BITS-1:0] BAUDOT_LTRS = 5'b11111;
    localparam logic [BAUDOT_BITS-1:0] BAUDOT_FIGS = 5'b11011;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/baudot_rx_framer_if.sv
// Character output bundle of the Baudot receive framer.
//   code_out    : last good 5-bit code, bit 0 = first data bit on the line
//   code_valid  : one-cycle strobe, code_out valid in that cycle
//   figs_mode   : shift state, 0 = LTRS, 1 = FIGS
//   framing_err : one-cycle strobe when the stop bit was space
//   busy        : framer is inside a frame
// master = framer side, slave = consumer (serialiser) side.
interface baudot_rx_framer_if;
    import baudot_pkg::*;

    logic [BAUDOT_BITS-1:0] code_out;
    logic                   code_valid;
    logic                   figs_mode;
    logic                   framing_err;
    logic                   busy;

    modport master (
        output code_out,
        output code_valid,
        output figs_mode,
        output framing_err,
        output busy
    );

    modport slave (
        input code_out,
        input code_valid,
        input figs_mode,
        input framing_err,
        input busy
    );

endinterface

// File: rtl/baudot_line_filter.sv
// Input conditioning for the raw teletype line: 2-FF synchroniser followed by a
// 3-tap majority filter with a registered output. Every flop resets to mark so
// a reset never looks like a start bit.
//   clk_baudot : sample clock
//   rst_n      : synchronous active-low reset
//   line_in    : asynchronous line, 1 = mark
//   filt       : synchronised, deglitched line (3 cycles behind line_in)
module baudot_line_filter
    import baudot_pkg::*;
(
    input  logic clk_baudot,
    input  logic rst_n,
    input  logic line_in,
    output logic filt
);

    logic s1, s2, s2_d1, s2_d2, filt_q;

    always_ff @(posedge clk_baudot) begin
        if (!rst_n) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            s2_d1  <= 1'b1;
            s2_d2  <= 1'b1;
            filt_q <= 1'b1;
        end else begin
            s1     <= line_in;
            s2     <= s1;
            s2_d1  <= s2;
            s2_d2  <= s2_d1;
            filt_q <= majority3(s2, s2_d1, s2_d2);
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/baudot_rx_framer.sv
// Baudot (ITA2) asynchronous receive framer. Oversamples the line, finds the
// start bit, samples five data bits LSB first at mid-bit, checks the stop bit
// and tracks the LTRS/FIGS shift state.
//   clk_baudot : sample clock, OVERSAMPLE x baud rate
//   rst_n      : synchronous active-low reset
//   line_in    : raw asynchronous line, 1 = mark (idle)
//   rx         : character output bundle (master side)
// OVERSAMPLE must be a power of two and at least 4.
module baudot_rx_framer
    import baudot_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                clk_baudot,
    input  logic                rst_n,
    input  logic                line_in,
    baudot_rx_framer_if.master  rx
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       BIDX_LAST = 3'(BAUDOT_BITS - 1);

    logic filt;

    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bidx_q, bidx_d;
    logic                   armed_q, armed_d;
    logic [BAUDOT_BITS-1:0] shift_q, shift_d;
    logic [BAUDOT_BITS-1:0] code_q, code_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   figs_q, figs_d;

    baudot_line_filter u_filter (
        .clk_baudot (clk_baudot),
        .rst_n      (rst_n),
        .line_in    (line_in),
        .filt       (filt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        armed_d = armed_q;
        shift_d = shift_q;
        code_d  = code_q;
        figs_d  = figs_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (armed_q) begin
                    if (!filt) begin
                        state_d = StStart;
                        cnt_d   = '0;
                    end
                end else if (filt) begin
                    // Require a full bit time of mark before trusting a start edge.
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        armed_d = 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            StStart: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (filt) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        bidx_d  = '0;
                    end
                end
            end

            StData: begin
                // Counter wraps to 0 on its own, keeping samples one bit apart.
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    shift_d[bidx_q] = filt;
                    if (bidx_q == BIDX_LAST) begin
                        state_d = StStop;
                    end else begin
                        bidx_d = bidx_q + 3'd1;
                    end
                end
            end

            StStop: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    if (filt) begin
                        valid_d = 1'b1;
                        code_d  = shift_q;
                        armed_d = 1'b1;
                        if (shift_q == BAUDOT_LTRS) begin
                            figs_d = 1'b0;
                        end else if (shift_q == BAUDOT_FIGS) begin
                            figs_d = 1'b1;
                        end
                    end else begin
                        // Disarm so a held break reports a single error.
                        err_d   = 1'b1;
                        armed_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_baudot) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bidx_q  <= '0;
            armed_q <= 1'b0;
            shift_q <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            figs_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            armed_q <= armed_d;
            shift_q <= shift_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            figs_q  <= figs_d;
        end
    end

    assign rx.code_out    = code_q;
    assign rx.code_valid  = valid_q;
    assign rx.framing_err = err_q;
    assign rx.figs_mode   = figs_q;
    assign rx.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_baudot_rx_framer.sv
// Scoreboard bench for baudot_rx_framer with OVERSAMPLE = 16. Stimulus tasks push
// the expected strobe (kind, code, shift state, cycle) when a frame is started;
// a negedge monitor pops and compares whenever code_valid or framing_err fires.
module tb_baudot_rx_framer;
    import baudot_pkg::*;

    localparam int unsigned OV = 16;
    // Line set after edge s is first sampled at edge s+1; filter adds 3, start
    // sample at +OV/2, five data bits and the stop bit at +6*OV, strobe +1.
    localparam int unsigned STROBE_LAT = 1 + 3 + OV / 2 + 6 * OV + 1;

    typedef struct {
        logic                   is_err;
        logic [BAUDOT_BITS-1:0] code;
        logic                   figs;
        int unsigned            at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line_in = 1'b1;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        model_figs = 1'b0;
    exp_t        sb[$];

    baudot_rx_framer_if rx_if ();

    baudot_rx_framer #(
        .OVERSAMPLE (OV)
    ) dut (
        .clk_baudot (clk),
        .rst_n      (rst_n),
        .line_in    (line_in),
        .rx         (rx_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (rx_if.code_valid || rx_if.framing_err)) begin
            check_val("strobe_exclusive", int'(rx_if.code_valid && rx_if.framing_err), 0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe at cycle %0d: got valid=%0d err=%0d code=%b, expected none",
                         cyc, rx_if.code_valid, rx_if.framing_err, rx_if.code_out);
            end else begin
                e = sb.pop_front();
                check_val("strobe_cycle", int'(cyc), int'(e.at));
                check_val("strobe_is_err", int'(rx_if.framing_err), int'(e.is_err));
                check_val("strobe_figs", int'(rx_if.figs_mode), int'(e.figs));
                if (!e.is_err) begin
                    check_val("strobe_code", int'(rx_if.code_out), int'(e.code));
                end
            end
        end
    end

    task automatic hold(input logic v, input int unsigned n);
        line_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        check_val({name, "_code"}, int'(rx_if.code_out), 0);
        check_val({name, "_valid"}, int'(rx_if.code_valid), 0);
        check_val({name, "_err"}, int'(rx_if.framing_err), 0);
        check_val({name, "_figs"}, int'(rx_if.figs_mode), 0);
        check_val({name, "_busy"}, int'(rx_if.busy), 0);
    endtask

    // Start bit, five data bits LSB first, then stop_len cycles of stop_val.
    // glitch_bit >= 0 inverts one cycle in the middle of that data bit.
    task automatic send_frame(input logic [BAUDOT_BITS-1:0] code, input int unsigned stop_len,
                              input logic stop_val, input int glitch_bit);
        exp_t e;
        e.is_err = !stop_val;
        e.code   = code;
        e.at     = cyc + STROBE_LAT;
        if (stop_val) begin
            if (code == 5'b11111) model_figs = 1'b0;
            else if (code == 5'b11011) model_figs = 1'b1;
        end
        e.figs = model_figs;
        sb.push_back(e);
        hold(1'b0, OV);
        for (int k = 0; k < BAUDOT_BITS; k++) begin
            for (int i = 0; i < int'(OV); i++) begin
                line_in = (k == glitch_bit && i == int'(OV / 2)) ? ~code[k] : code[k];
                @(posedge clk);
                #1;
            end
        end
        hold(stop_val, stop_len);
    endtask

    initial begin : stimulus
        int unsigned s;

        rst_n   = 1'b0;
        line_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        hold(1'b1, 32);
        check_val("idle_busy", int'(rx_if.busy), 0);

        // 'A' with 1.5 stop bits
        send_frame(5'b00011, 24, 1'b1, -1);
        hold(1'b1, 20);

        // FIGS, 'A', LTRS
        send_frame(5'b11011, 24, 1'b1, -1);
        send_frame(5'b00011, 24, 1'b1, -1);
        send_frame(5'b11111, 24, 1'b1, -1);
        hold(1'b1, 20);

        // 4-cycle space pulse: false start, busy from E0+1 to E0+9
        s = cyc;
        hold(1'b0, 4);
        line_in = 1'b1;
        wait_until(s + 4);
        check_val("false_start_busy_e0", int'(rx_if.busy), 0);
        wait_until(s + 5);
        check_val("false_start_busy_e0p1", int'(rx_if.busy), 1);
        wait_until(s + 12);
        check_val("false_start_busy_e0p8", int'(rx_if.busy), 1);
        wait_until(s + 13);
        check_val("false_start_busy_e0p9", int'(rx_if.busy), 0);
        hold(1'b1, 20);
        send_frame(5'b10101, 24, 1'b1, -1);
        hold(1'b1, 10);

        // Break: stop bit space, then 100 more cycles of space
        send_frame(5'b01010, 0, 1'b0, -1);
        hold(1'b0, OV + 100);
        hold(1'b1, 8);
        s = cyc;
        hold(1'b0, 20);
        check_val("break_rearm_busy", int'(rx_if.busy), 0);
        hold(1'b1, 24);
        send_frame(5'b10110, 24, 1'b1, -1);
        hold(1'b1, 10);

        // Back to back, 1 stop bit, glitch in data bit 2 of the first
        send_frame(5'b10100, 16, 1'b1, 2);
        send_frame(5'b01001, 16, 1'b1, -1);
        hold(1'b1, 20);

        // Reset in the middle of data bit 3
        send_frame(5'b11011, 24, 1'b1, -1);
        hold(1'b1, 20);
        hold(1'b0, OV);
        hold(1'b1, OV);
        hold(1'b1, OV);
        hold(1'b0, OV);
        hold(1'b1, OV / 2);
        check_val("pre_reset_busy", int'(rx_if.busy), 1);
        line_in = 1'b0;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        check_zero("mid_reset");
        model_figs = 1'b0;
        rst_n = 1'b1;
        hold(1'b0, 30);
        check_val("post_reset_low_busy", int'(rx_if.busy), 0);
        hold(1'b1, 10);
        hold(1'b0, 20);
        check_val("post_reset_short_mark_busy", int'(rx_if.busy), 0);
        hold(1'b1, 24);
        send_frame(5'b00011, 24, 1'b1, -1);
        hold(1'b1, 20);

        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        check_val("queue_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d strobes still expected", sb.size());
        $fatal(1);
    end

endmodule
